// File: rtl/frame_writer_pkg.sv
// rtl/frame_writer_pkg.sv - shared geometry, widths and state encoding for frame_writer
package frame_writer_pkg;

  localparam int SRC_W    = 640;
  localparam int SRC_H    = 480;
  localparam int DST_W    = SRC_W / 2;
  localparam int DST_H    = SRC_H / 2;
  localparam int FB_DEPTH = DST_W * DST_H;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 24;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/frame_writer_raster_counter.sv
// rtl/frame_writer_raster_counter.sv - source x/y raster position with end-of-line and last-line flags
module raster_counter
  import frame_writer_pkg::*;
#(
  parameter int SRC_W = frame_writer_pkg::SRC_W,
  parameter int SRC_H = frame_writer_pkg::SRC_H
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inc,
  input  logic                                load_origin,
  input  logic                                clear,
  output logic [frame_writer_pkg::X_W-1:0]    x_cnt,
  output logic [frame_writer_pkg::Y_W-1:0]    y_cnt,
  output logic                                eol,
  output logic                                eof
);

  logic [X_W-1:0] x_cnt_d, x_cnt_q;
  logic [Y_W-1:0] y_cnt_d, y_cnt_q;

  assign x_cnt = x_cnt_q;
  assign y_cnt = y_cnt_q;
  // eof flags the last line; the last pixel of the frame is eol on that line
  assign eol   = (x_cnt_q == X_W'(SRC_W - 1));
  assign eof   = (y_cnt_q == Y_W'(SRC_H - 1));

  // Next position: clear wins, then origin load (origin pixel already consumed), then advance
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (clear) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (load_origin) begin
      x_cnt_d = X_W'(1);
      y_cnt_d = '0;
    end else if (inc) begin
      if (eol) begin
        x_cnt_d = '0;
        y_cnt_d = y_cnt_q + Y_W'(1);
      end else begin
        x_cnt_d = x_cnt_q + X_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - pops FWFT pixel stream, keeps even x/even y, writes 2:1 decimated frame
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int SRC_W  = frame_writer_pkg::SRC_W,
  parameter int SRC_H  = frame_writer_pkg::SRC_H,
  parameter int ADDR_W = frame_writer_pkg::ADDR_W,
  parameter int DATA_W = frame_writer_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              empty,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              sof,
  output logic              re,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_wdata,
  output logic              frame_we,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [ADDR_W-1:0] frame_addr_d, frame_addr_q;
  logic [DATA_W-1:0] frame_wdata_d, frame_wdata_q;
  logic              frame_we_d, frame_we_q;
  logic              frame_done_d, frame_done_q;
  logic              frame_err_d, frame_err_q;

  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic              eol, eof;
  logic              inc, load_origin, clear;
  logic              pop, keep, at_origin, last_pix;

  // The write port never stalls, so anything at the FIFO head is consumed
  assign re        = ~empty;
  assign pop       = ~empty;
  assign keep      = ~x_cnt[0] & ~y_cnt[0];
  assign at_origin = (x_cnt == '0) && (y_cnt == '0);
  assign last_pix  = eol & eof;

  assign frame_addr  = frame_addr_q;
  assign frame_wdata = frame_wdata_q;
  assign frame_we    = frame_we_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == RUN);

  raster_counter #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H)
  ) u_raster (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (inc),
    .load_origin (load_origin),
    .clear       (clear),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .eol         (eol),
    .eof         (eof)
  );

  // Next-state: sof always restarts at the origin (error if mid-frame), else advance and write kept pixels
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    frame_addr_d  = frame_addr_q;
    frame_wdata_d = frame_wdata_q;
    frame_we_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    inc           = 1'b0;
    load_origin   = 1'b0;
    clear         = 1'b0;
    if (pop) begin
      if (sof && ((state_q == SYNC) || !at_origin)) begin
        frame_err_d   = (state_q == RUN);
        frame_we_d    = 1'b1;
        frame_addr_d  = '0;
        frame_wdata_d = pix_data;
        wr_addr_d     = ADDR_W'(1);
        load_origin   = 1'b1;
        state_d       = RUN;
      end else if (state_q == RUN) begin
        if (keep) begin
          frame_we_d    = 1'b1;
          frame_addr_d  = wr_addr_q;
          frame_wdata_d = pix_data;
          wr_addr_d     = wr_addr_q + ADDR_W'(1);
        end
        if (last_pix) begin
          frame_done_d = 1'b1;
          clear        = 1'b1;
          wr_addr_d    = '0;
          state_d      = SYNC;
        end else begin
          inc = 1'b1;
        end
      end
    end
  end

  // State, address counter and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      wr_addr_q     <= '0;
      frame_addr_q  <= '0;
      frame_wdata_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      frame_addr_q  <= frame_addr_d;
      frame_wdata_q <= frame_wdata_d;
      frame_we_q    <= frame_we_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule
